load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute/memory pipeline stage and the word-only, single-cycle-latency data memory.
- Converts byte, halfword and word load/store requests into word accesses.
- Sub-word stores use read-modify-write. Loads get lane select plus sign/zero extension.
- Little-endian; misaligned requests are flagged and never touch memory.

Parameters:
- DATA_WIDTH, 32, data word width (fixed at 32 for lane logic)
- ADDRESS_WIDTH, 32, byte address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit accepts request this cycle
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, low-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores/errors
- resp_error  out  1  misaligned/reserved-size request
- mem_address  out  ADDRESS_WIDTH  to memory address
- mem_write_data  out  DATA_WIDTH  to memory write data
- mem_write_enable  out  1  to memory write enable
- mem_read_data  in  DATA_WIDTH  memory read data, valid the cycle after the address is presented

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_error=0. Latched request registers are cleared to 0.
- States: IDLE, LD_DATA, ST_MERGE, RESP.
- req_ready=1 only in IDLE and rst=0. Accept = req_valid & req_ready. The request is latched at accept.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Accept goes to RESP with resp_error=1 and resp_rdata=0.
  - No memory write.
- mem_address (combinational): req_addr in IDLE; latched address otherwise. Memory ignores addr[1:0].
- Aligned word store:
  - The accept cycle drives mem_write_enable=1 and mem_write_data=req_wdata.
  - Next state RESP; resp_valid at accept+1.
- Load:
  - The accept cycle presents the address with mem_write_enable=0, then goes to LD_DATA.
  - LD_DATA extracts the lane from mem_read_data and registers it into resp_rdata, then goes to RESP.
  - resp_valid at accept+2.
  - Byte lane = addr[1:0], bits [8k+7:8k]. Half lane = addr[1], bits [16h+15:16h]. Word passes through.
  - Extension: req_unsigned=1 zero-fills; req_unsigned=0 replicates the lane MSB.
- Sub-word store:
  - The accept cycle issues a read (we=0), then goes to ST_MERGE.
  - ST_MERGE: mem_write_data = mem_read_data with the target lane replaced by wdata[7:0] or wdata[15:0]. Other bytes are preserved; mem_write_enable=1.
  - Then RESP; resp_valid at accept+2.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE. Back-to-back: the next accept is possible the cycle after RESP.
- Memory reads are read-before-write. A load issued right after a store to the same word sees the new data, because the store completed before the load's address cycle.
- mem_write_enable is forced 0 whenever rst=1.
- Reset during LD_DATA/ST_MERGE abandons the operation: no write, no response.
- No response back-pressure; the consumer is always ready.
- Inputs are ignored outside accept.

Decomposition:
- Package lsu_pkg holds:
  - size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD)
  - state enum (IDLE, LD_DATA, ST_MERGE, RESP)
  - function is_misaligned(size, addr[1:0])
- Sub-module lsu_load_align: combinational lane select and extension (inputs word, addr[1:0], size, unsigned; output data). Also reused for the store-merge lane mask.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10, then load word @0x10. Expect mem_write_enable at the accept cycle; resp_valid at +1, then +2; resp_rdata=0xDEADBEEF, resp_error=0.
- Byte RMW: memory @0x20=0x11223344, store byte 0xAA @0x22. Expect one read cycle, then a write of 0x11AA3344; load word returns 0x11AA3344.
- Extension: @0x30=0x80F0017F.
  - lb @0x33 -> 0xFFFFFF80; lbu @0x33 -> 0x00000080.
  - lh @0x32 -> 0xFFFF80F0; lhu @0x30 -> 0x0000017F.
- Misaligned: lw @0x05, sh @0x03, size=11 @0x00. Each gives resp_error=1 at accept+1, resp_rdata=0, mem_write_enable never 1, and memory is unchanged.
- Reset mid-RMW: assert rst during ST_MERGE of sb 0x55 @0x40 (old 0x00000000). Expect no write, no resp_valid, IDLE with req_ready=1 the cycle after rst deasserts, and memory still 0x00000000.
- Throughput: 4 back-to-back word stores with req_valid held high. Expect accepts every 2 cycles, 4 resp_valid pulses, and req_ready=0 during RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and alignment helper for the load/store unit
//
// Purpose: access-size and FSM state encodings plus the misalignment rule,
// shared by load_store_unit and lsu_load_align.
// Ports: none (package).

package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LD_DATA  = 2'b01,
        ST_MERGE = 2'b10,
        RESP     = 2'b11
    } state_e;

    // Size code 2'b11 is reserved and is reported the same way as a
    // misaligned access so it can never reach memory.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic result;
        case (size)
            SIZE_BYTE: result = 1'b0;
            SIZE_HALF: result = addr_lo[0];
            SIZE_WORD: result = (addr_lo != 2'b00);
            default:   result = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - little-endian lane select, extension and lane mask
//
// Purpose: extracts the byte/halfword lane addressed by addr_lo from a memory
// word and sign- or zero-extends it; also reports which byte lanes the access
// covers so the store path can merge sub-word data into a read word.
// Ports:
//   word         in  32  memory word
//   addr_lo      in  2   byte offset within the word
//   size         in  2   access size code
//   unsigned_ext in  1   1 = zero-extend, 0 = sign-extend
//   data         out 32  extended lane data (word passes through)
//   lane_mask    out 4   byte lanes touched by the access

import lsu_pkg::*;

module lsu_load_align (
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        unsigned_ext,
    output logic [31:0] data,
    output logic [3:0]  lane_mask
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        fill;

    always_comb begin
        byte_lane = word[{addr_lo, 3'b000} +: 8];
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
        fill      = 1'b0;
        data      = word;
        lane_mask = 4'b1111;
        case (size)
            SIZE_BYTE: begin
                fill      = ~unsigned_ext & byte_lane[7];
                data      = {{24{fill}}, byte_lane};
                lane_mask = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                fill      = ~unsigned_ext & half_lane[15];
                data      = {{16{fill}}, half_lane};
                lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                data      = word;
                lane_mask = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit over word-only memory
//
// Purpose: turns byte, halfword and word requests into single-word accesses
// to a one-cycle-latency memory. Sub-word stores read-modify-write, loads are
// lane-selected and extended, misaligned or reserved-size requests are
// answered with an error and never touch memory.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_write, req_size       store flag and access size
//   req_unsigned              load zero-extend select
//   req_addr, req_wdata       byte address and low-aligned store data
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_error    load data (0 for stores/errors), error flag
//   mem_address               word memory address (addr[1:0] ignored by memory)
//   mem_write_data/enable     memory write port
//   mem_read_data             memory data, valid the cycle after the address

import lsu_pkg::*;

module load_store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_error,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_write_enable,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    state_e                   state;
    state_e                   state_next;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [1:0]               size_q;
    logic                     unsigned_q;
    logic [15:0]              wdata_q;      // only sub-word stores need data after accept

    logic                     accept;
    logic                     misaligned;
    logic [31:0]              load_data;
    logic [3:0]               lane_mask;
    logic [31:0]              lane_bits;
    logic [31:0]              store_repl;
    logic [31:0]              merge_data;

    assign req_ready   = (state == IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign misaligned  = is_misaligned(req_size, req_addr[1:0]);
    assign resp_valid  = (state == RESP);
    assign mem_address = (state == IDLE) ? req_addr : addr_q;

    // One aligner serves both paths: its data output feeds load responses,
    // its lane mask selects which bytes of the read word a store replaces.
    lsu_load_align u_align (
        .word         (mem_read_data),
        .addr_lo      (addr_q[1:0]),
        .size         (size_q),
        .unsigned_ext (unsigned_q),
        .data         (load_data),
        .lane_mask    (lane_mask)
    );

    assign lane_bits  = {{8{lane_mask[3]}}, {8{lane_mask[2]}},
                         {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    // Replicating the store data across the word puts it under every lane,
    // so the mask alone picks the target position.
    assign store_repl = (size_q == SIZE_BYTE) ? {4{wdata_q[7:0]}} : {2{wdata_q}};
    assign merge_data = (mem_read_data & ~lane_bits) | (store_repl & lane_bits);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        case (state)
            IDLE: begin
                mem_write_data = req_wdata;
                if (accept) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else if (!req_write) begin
                        state_next = LD_DATA;
                    end else if (req_size == SIZE_WORD) begin
                        mem_write_enable = 1'b1;
                        state_next       = RESP;
                    end else begin
                        state_next = ST_MERGE;
                    end
                end
            end
            LD_DATA: begin
                state_next = RESP;
            end
            ST_MERGE: begin
                // A reset here abandons the merge without writing.
                mem_write_data   = merge_data;
                mem_write_enable = !rst;
                state_next       = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else if (accept) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            resp_rdata <= '0;
            resp_error <= misaligned;
        end else if (state == LD_DATA) begin
            resp_rdata <= load_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Word memory, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        mem_read_data <= mem[mem_address[9:2]];
        if (mem_write_enable && (mem_address[31:10] == 22'h0))
            mem[mem_address[9:2]] <= mem_write_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request at the current negedge and follows it to its
    // response, recording latency and any memory writes on the way.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int nwe, output int first_we, output logic [31:0] wdat,
                           output logic rdy_resp);
        lat = 0; nwe = 0; first_we = -1; wdat = 32'h0;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        #1;
        while (!resp_valid && lat < 8) begin
            if (mem_write_enable) begin
                if (nwe == 0) first_we = lat;
                nwe++;
                wdat = mem_write_data;
            end
            @(negedge clk);
            req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0BAD_0BAD;
            req_size = 2'b10; req_write = ~w;
            #1;
            lat++;
        end
        rdata = resp_rdata; err = resp_error; rdy_resp = req_ready;
        @(negedge clk);
    endtask

    initial begin
        int          lat, nwe, fwe, acc, nresp, rdy_bad;
        int          acc_cyc [0:3];
        logic [31:0] rd, wdat;
        logic        err, rr;

        // Reset, with a word store held on the inputs
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_addr = 32'h0; req_wdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        #1;
        check("rst_we", mem_write_enable, 32'h0);
        check("rst_ready", req_ready, 32'h0);
        check("rst_resp_valid", resp_valid, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_error", resp_error, 32'h0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check("idle_ready", req_ready, 32'h1);
        @(negedge clk);

        // Word store then word load
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, err, nwe, fwe, wdat, rr);
        check("sw_latency", lat, 32'd1);
        check("sw_we_count", nwe, 32'd1);
        check("sw_we_cycle", fwe, 32'd0);
        check("sw_wdata", wdat, 32'hDEAD_BEEF);
        check("sw_error", err, 32'h0);
        check("sw_rdata", rd, 32'h0);
        check("sw_ready_in_resp", rr, 32'h0);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lw_latency", lat, 32'd2);
        check("lw_we_count", nwe, 32'd0);
        check("lw_rdata", rd, 32'hDEAD_BEEF);
        check("lw_error", err, 32'h0);

        // Byte and halfword read-modify-write
        run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, lat, rd, err, nwe, fwe, wdat, rr);
        run_req(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFF_FFAA, lat, rd, err, nwe, fwe, wdat, rr);
        check("sb_latency", lat, 32'd2);
        check("sb_we_count", nwe, 32'd1);
        check("sb_we_cycle", fwe, 32'd1);
        check("sb_merge", wdat, 32'h11AA_3344);
        check("sb_rdata", rd, 32'h0);
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("sb_readback", rd, 32'h11AA_3344);
        run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, lat, rd, err, nwe, fwe, wdat, rr);
        check("sh_merge", wdat, 32'hBEEF_3344);
        check("sh_mem", mem[8], 32'hBEEF_3344);
        run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0077, lat, rd, err, nwe, fwe, wdat, rr);
        check("sb1_merge", wdat, 32'hBEEF_7744);

        // Load lane select and extension
        run_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h80F0_017F, lat, rd, err, nwe, fwe, wdat, rr);
        run_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lb_33", rd, 32'hFFFF_FF80);
        check("lb_latency", lat, 32'd2);
        run_req(1'b0, 2'b00, 1'b1, 32'h33, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lbu_33", rd, 32'h0000_0080);
        run_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lh_32", rd, 32'hFFFF_80F0);
        run_req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lhu_30", rd, 32'h0000_017F);
        run_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lb_30", rd, 32'h0000_007F);
        run_req(1'b0, 2'b00, 1'b1, 32'h32, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lbu_32", rd, 32'h0000_00F0);
        run_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lhu_32", rd, 32'h0000_80F0);

        // Misaligned and reserved-size requests
        run_req(1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFE_F00D, lat, rd, err, nwe, fwe, wdat, rr);
        run_req(1'b1, 2'b10, 1'b0, 32'h04, 32'h0102_0304, lat, rd, err, nwe, fwe, wdat, rr);
        run_req(1'b0, 2'b10, 1'b0, 32'h05, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lw05_latency", lat, 32'd1);
        check("lw05_error", err, 32'h1);
        check("lw05_rdata", rd, 32'h0);
        check("lw05_we", nwe, 32'd0);
        check("lw05_mem", mem[1], 32'h0102_0304);
        run_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h0000_FFFF, lat, rd, err, nwe, fwe, wdat, rr);
        check("sh03_latency", lat, 32'd1);
        check("sh03_error", err, 32'h1);
        check("sh03_we", nwe, 32'd0);
        check("sh03_mem", mem[0], 32'hCAFE_F00D);
        run_req(1'b1, 2'b11, 1'b0, 32'h00, 32'h0000_0000, lat, rd, err, nwe, fwe, wdat, rr);
        check("sz11_latency", lat, 32'd1);
        check("sz11_error", err, 32'h1);
        check("sz11_rdata", rd, 32'h0);
        check("sz11_we", nwe, 32'd0);
        check("sz11_mem", mem[0], 32'hCAFE_F00D);
        run_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, lat, rd, err, nwe, fwe, wdat, rr);
        check("lw00_error_clear", err, 32'h0);
        check("lw00_rdata", rd, 32'hCAFE_F00D);

        // Reset during ST_MERGE abandons the store
        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h0000_0000, lat, rd, err, nwe, fwe, wdat, rr);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0000_0055;
        #1;
        check("rmw_read_cycle_we", mem_write_enable, 32'h0);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        #1;
        check("rmw_rst_we", mem_write_enable, 32'h0);
        check("rmw_rst_resp", resp_valid, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmw_after_ready", req_ready, 32'h1);
        check("rmw_after_resp", resp_valid, 32'h0);
        @(negedge clk);
        #1;
        check("rmw_no_late_resp", resp_valid, 32'h0);
        check("rmw_mem", mem[16], 32'h0000_0000);
        @(negedge clk);

        // Back-to-back word stores with req_valid held high
        acc = 0; nresp = 0; rdy_bad = 0;
        for (int k = 0; k < 4; k++) acc_cyc[k] = -1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        for (int c = 0; c < 8; c++) begin
            req_addr  = 32'h50 + 32'(acc) * 4;
            req_wdata = 32'hA000_0000 + 32'(acc);
            #1;
            if (req_ready) begin
                if (acc < 4) acc_cyc[acc] = c;
                acc++;
            end
            if (resp_valid) begin
                nresp++;
                if (req_ready) rdy_bad++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_accepts", acc, 32'd4);
        check("b2b_resps", nresp, 32'd4);
        check("b2b_ready_in_resp", rdy_bad, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b_accept_cycle_%0d", k), acc_cyc[k], 32'(2 * k));
            check($sformatf("b2b_mem_%0d", k), mem[20 + k], 32'hA000_0000 + 32'(k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
